// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding, S-box ROM and round-key slicing.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int AES128_NR      = 10;
  localparam int AES192_NR      = 12;
  localparam int AES256_NR      = 14;
  localparam int AES_MAX_KEYS_W = (AES256_NR + 1) * AES_BLOCK_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  // Keys arrive MSB-aligned in an AES-256 sized bus, key 0 at the top.
  function automatic logic [AES_BLOCK_W-1:0] key_slice(input logic [AES_MAX_KEYS_W-1:0] keys,
                                                       input int k);
    return keys[AES_MAX_KEYS_W - 1 - AES_BLOCK_W * k -: AES_BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing block owns all flow control.
module aes_round_stage
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] blk,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] blk_next
);

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = sbox_lookup(s[127 - 8 * i -: 8]);
    return o;
  endfunction

  // Byte index is 4*col+row; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  logic [AES_BLOCK_W-1:0] shifted;

  assign shifted  = shift_rows(sub_bytes(blk));
  assign blk_next = add_round_key(last_round ? shifted : mix_columns(shifted), round_key);

endmodule

// File: rtl/aes_enc_round_iter.sv
// Iterative AES encryptor: whitening on accept, then ROUNDS_PER_CYCLE rounds per clock.
// Latency: NR/ROUNDS_PER_CYCLE cycles from accept edge to outValid.
// Backpressure: single block in flight; holds result in DONE until inReady, no accept while busy.
module aes_enc_round_iter
  import aes_pkg::*;
#(
  parameter  int NR               = AES256_NR,
  parameter  int ROUNDS_PER_CYCLE = 1,
  localparam int KEYS_W           = (NR + 1) * AES_BLOCK_W
) (
  input  logic                   inClk,
  input  logic                   inRstN,
  input  logic [AES_BLOCK_W-1:0] inData,
  input  logic [KEYS_W-1:0]      inKeys,
  input  logic                   inValid,
  output logic                   outReady,
  output logic [AES_BLOCK_W-1:0] outData,
  output logic                   outValid,
  input  logic                   inReady,
  output logic                   outBusy
);

  localparam int               STEPS    = NR / ROUNDS_PER_CYCLE;
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if (NR != AES128_NR && NR != AES192_NR && NR != AES256_NR) begin : g_bad_nr
    $error("aes_enc_round_iter: NR must be 10, 12 or 14");
  end
  if (NR % ROUNDS_PER_CYCLE != 0) begin : g_bad_rpc
    $error("aes_enc_round_iter: ROUNDS_PER_CYCLE must divide NR");
  end

  aes_state_e             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [KEYS_W-1:0]      key_reg, key_nxt;
  logic [AES_BLOCK_W-1:0] st_reg, st_nxt;
  logic [AES_BLOCK_W-1:0] res_reg, res_nxt;

  logic [AES_MAX_KEYS_W-1:0]                   keys_al;
  logic [ROUNDS_PER_CYCLE:0][AES_BLOCK_W-1:0] chain;

  // Left-align the schedule so key_slice works for every key size.
  assign keys_al  = AES_MAX_KEYS_W'(key_reg) << (AES_MAX_KEYS_W - KEYS_W);
  assign chain[0] = st_reg;

  for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
    int rnd;
    assign rnd = int'(cnt) * ROUNDS_PER_CYCLE + gi + 1;
    aes_round_stage u_stage (
      .blk       (chain[gi]),
      .round_key (key_slice(keys_al, rnd)),
      .last_round(rnd == NR),
      .blk_next  (chain[gi+1])
    );
  end

  // State, counter and datapath registers; reset clears everything including the result.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state   <= IDLE;
      cnt     <= '0;
      key_reg <= '0;
      st_reg  <= '0;
      res_reg <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      key_reg <= key_nxt;
      st_reg  <= st_nxt;
      res_reg <= res_nxt;
    end
  end

  // Next-state and datapath update: accept in IDLE, iterate in RUN, hold in DONE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_nxt   = key_reg;
    st_nxt    = st_reg;
    res_nxt   = res_reg;
    case (state)
      IDLE: begin
        if (inValid) begin
          key_nxt   = inKeys;
          st_nxt    = inData ^ inKeys[KEYS_W-1 -: AES_BLOCK_W];
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        st_nxt  = chain[ROUNDS_PER_CYCLE];
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          res_nxt   = chain[ROUNDS_PER_CYCLE];
          // Parked at zero so the round index never points past the schedule.
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (inReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated with reset so ready is low while the block is held in reset.
  assign outReady = inRstN & (state == IDLE);
  assign outValid = (state == DONE);
  assign outBusy  = (state != IDLE);
  assign outData  = res_reg;

endmodule
